// File: rtl/vdp_cpu_interface.sv
// CPU-side I/O responder for the V9918 core.
// Decodes the data port (IO_BASE) and the control port (IO_BASE+1), keeps the
// two-byte control latch, the auto-incrementing 14-bit VRAM address and the
// read-ahead buffer, and issues single-byte VRAM requests on the DRAM bus.
module vdp_cpu_interface #(
    parameter logic [7:0] IO_BASE = 8'h98
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_address,
    input  logic        bus_ioreq,
    input  logic        bus_write,
    input  logic        bus_valid,
    output logic        bus_ready,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    output logic        bus_rdata_en,
    output logic [13:0] dram_address,
    output logic        dram_write,
    output logic        dram_valid,
    input  logic        dram_ready,
    output logic [7:0]  dram_wdata,
    input  logic [7:0]  dram_rdata,
    input  logic        dram_rdata_en,
    output logic        reg_write,
    output logic [2:0]  reg_num,
    output logic [7:0]  reg_data,
    input  logic [7:0]  status_in,
    output logic        status_read
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR_REQ  = 2'd1;
    localparam logic [1:0] ST_RD_REQ  = 2'd2;
    localparam logic [1:0] ST_RD_WAIT = 2'd3;

    logic [1:0]  state;
    logic        latch_full;
    logic [7:0]  latch_byte;
    logic [13:0] vram_addr;
    logic [7:0]  read_buf;
    logic [7:0]  write_buf;

    logic        hit;
    logic        access;
    logic        is_ctrl;
    logic        unused_addr_hi;

    // The upper I/O address byte does not take part in the decode.
    assign unused_addr_hi = ^bus_address[15:8];

    assign hit       = (bus_address[7:1] == IO_BASE[7:1]);
    assign is_ctrl   = bus_address[0];
    assign bus_ready = (state == ST_IDLE);
    assign access    = bus_ioreq & bus_valid & hit & bus_ready;

    // DRAM request signals follow the FSM state directly, so an asynchronous
    // reset drops dram_valid in the same cycle without waiting for a clock.
    assign dram_valid   = (state == ST_WR_REQ) || (state == ST_RD_REQ);
    assign dram_write   = (state == ST_WR_REQ);
    assign dram_address = vram_addr;
    assign dram_wdata   = write_buf;

    // Bus access decode, control latch, address counter and DRAM request FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            latch_full   <= 1'b0;
            latch_byte   <= 8'h00;
            vram_addr    <= 14'h0000;
            read_buf     <= 8'h00;
            write_buf    <= 8'h00;
            bus_rdata    <= 8'h00;
            bus_rdata_en <= 1'b0;
            reg_write    <= 1'b0;
            reg_num      <= 3'd0;
            reg_data     <= 8'h00;
            status_read  <= 1'b0;
        end else begin
            bus_rdata_en <= 1'b0;
            reg_write    <= 1'b0;
            status_read  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        if (!is_ctrl) begin
                            latch_full <= 1'b0;
                            if (bus_write) begin
                                write_buf <= bus_wdata;
                                state     <= ST_WR_REQ;
                            end else begin
                                // Return the buffered byte, then fetch the next one.
                                bus_rdata    <= read_buf;
                                bus_rdata_en <= 1'b1;
                                state        <= ST_RD_REQ;
                            end
                        end else if (bus_write) begin
                            if (!latch_full) begin
                                latch_byte <= bus_wdata;
                                latch_full <= 1'b1;
                            end else begin
                                latch_full <= 1'b0;
                                if (bus_wdata[7]) begin
                                    reg_write <= 1'b1;
                                    reg_num   <= bus_wdata[2:0];
                                    reg_data  <= latch_byte;
                                end else begin
                                    vram_addr <= {bus_wdata[5:0], latch_byte};
                                    // Read setup primes the read-ahead buffer.
                                    if (!bus_wdata[6]) begin
                                        state <= ST_RD_REQ;
                                    end
                                end
                            end
                        end else begin
                            bus_rdata    <= status_in;
                            bus_rdata_en <= 1'b1;
                            status_read  <= 1'b1;
                            latch_full   <= 1'b0;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (dram_ready) begin
                        vram_addr <= vram_addr + 14'd1;
                        state     <= ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    if (dram_ready) begin
                        vram_addr <= vram_addr + 14'd1;
                        state     <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (dram_rdata_en) begin
                        read_buf <= dram_rdata;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/vdp_cpu_interface.md
# vdp_cpu_interface

CPU-side I/O responder of the V9918 core. It decodes I/O accesses to the data port (IO_BASE) and the control port (IO_BASE+1), and implements the TMS9918 two-byte control latch, the 14-bit VRAM address auto-increment and the read-ahead buffer. It also generates VRAM access requests on the DRAM bus. It sits between the cartridge bus and the VRAM responder, alongside the register file and status logic.

## Interface
- IO_BASE, 8'h98, data port address; control port is IO_BASE+1; decode is bus_address[7:1]==IO_BASE[7:1].
- clk  in  1  42.95454 MHz system clock
- reset  in  1  asynchronous, active-high reset
- bus_address  in  16  I/O address (bits 15:8 ignored)
- bus_ioreq / bus_write / bus_valid  in  1 each  request qualifiers; access = ioreq & valid & decode hit
- bus_ready  out  1  access accepted this cycle when high together with valid
- bus_wdata  in  8  write data
- bus_rdata  out  8  read data, valid only while bus_rdata_en
- bus_rdata_en  out  1  single-cycle read-data strobe
- dram_address  out  14  VRAM address
- dram_write / dram_valid  out  1 each  request type and request strobe
- dram_ready  in  1  responder accepts request when high with dram_valid
- dram_wdata  out  8  VRAM write data
- dram_rdata  in  8  VRAM read data
- dram_rdata_en  in  1  read-data strobe from responder
- reg_write  out  1  one-cycle register write pulse
- reg_num  out  3  register number (wdata[2:0] of the second control byte)
- reg_data  out  8  register data (first control byte)
- status_in  in  8  status register value
- status_read  out  1  one-cycle pulse on each accepted status read; the status logic clears its flags on this pulse

## Operation
- Internal state: latch_full (1b), latch_byte (8b), vram_addr (14b), read_buf (8b), write_buf (8b), DRAM FSM {IDLE, WR_REQ, RD_REQ, RD_WAIT}.
- bus_ready = (fsm==IDLE). It is combinational, so it is high out of reset. A non-decoded access is ignored and never produces bus_rdata_en.
- Data port write: write_buf<=wdata, latch_full<=0, FSM->WR_REQ.
- Data port read: return read_buf, latch_full<=0, FSM->RD_REQ (prefetch of the next byte).
- Control port write, latch_full=0: latch_byte<=wdata, latch_full<=1.
- Control port write, latch_full=1, wdata[7]=1: reg_write pulse with reg_num=wdata[2:0] and reg_data=latch_byte. latch_full<=0.
- Control port write, latch_full=1, wdata[7]=0: vram_addr<={wdata[5:0],latch_byte}, latch_full<=0. If wdata[6]=0 (read setup), FSM->RD_REQ; otherwise FSM stays IDLE.
- Control port read: return status_in, pulse status_read, latch_full<=0.
- WR_REQ: dram_valid=1, dram_write=1, dram_address=vram_addr, dram_wdata=write_buf. On dram_ready: vram_addr++, FSM->IDLE.
- RD_REQ: dram_valid=1, dram_write=0, dram_address=vram_addr. On dram_ready: vram_addr++, FSM->RD_WAIT.
- RD_WAIT: on dram_rdata_en: read_buf<=dram_rdata, FSM->IDLE.
- vram_addr wraps 3FFFh->0000h.
- dram_valid and dram_write are deasserted in IDLE and RD_WAIT.

## Timing
- Reset values: bus_rdata=0, bus_rdata_en=0, dram_valid=0, dram_write=0, dram_address=0, dram_wdata=0, reg_write=0, reg_num=0, reg_data=0, status_read=0. All internal registers are 0 and the FSM is in IDLE.
- Read latency: bus_rdata_en is high exactly 1 cycle after the accepted access cycle, with bus_rdata registered.
- reg_write and status_read are high in the cycle after acceptance, for 1 cycle.
- FSM leaves IDLE in the cycle after acceptance, so bus_ready drops 1 cycle after acceptance.
- dram_valid holds, with stable address and data, until dram_ready.
- A prefetch completes no earlier than 3 cycles after acceptance, given a 0-wait responder that returns rdata_en 1 cycle after ready.
- While bus_ready=0, bus_valid is held by the initiator. No access is accepted or lost.
- A data port read started before a pending prefetch completes is stalled by bus_ready. It therefore always returns the newest read_buf.
- Reset asserted mid-request drops dram_valid immediately (asynchronous). A late dram_rdata_en arriving after reset release is ignored in IDLE.

## Test plan
- Write 00h to the control port, then 87h. The second write must pulse reg_write once, 1 cycle after acceptance, with reg_num=7 and reg_data=00h. latch_full must clear.
- Write 34h, then 52h to the control port, then write AAh to the data port. Expected: exactly one DRAM write with address 1234h and data AAh, after which vram_addr becomes 1235h. No read is issued.
- Write FFh, then 7Fh to the control port, then write 11h to the data port. The write must land at address 3FFFh and the next data port write must land at 0000h (wrap-around).
- Preload VRAM 0100h=5Ah and 0101h=A5h. Write 00h, then 01h to the control port. Expected: prefetch of address 0100h. The first data port read returns 5Ah and the second returns A5h, each with a 1-cycle bus_rdata_en.
- With status_in=9Fh, write 12h to the control port, then read the control port, then write 81h to the control port. Expected: the read returns 9Fh with a status_read pulse. The following 81h is taken as a first byte, so no reg_write occurs.
- Hold dram_ready=0 for 10 cycles during WR_REQ while the initiator retries a data port write. Expected: bus_ready stays 0 and dram signals are stable. Once dram_ready rises, the second write is accepted and lands at address+1. Assert reset mid-WR_REQ: dram_valid=0 the same cycle.
